// File: rtl/k005297_page_deserializer.sv
// K005297 bubble read path: hunts for the page sync word, then assembles MSB-first bytes.
// Define K005297_DESER_CRC_EN to build the CRC-16-CCITT residue check behind o_CRC_OK.
module k005297_page_deserializer #(
  parameter int          PAGE_BYTES   = 64,
  parameter logic [15:0] SYNC_WORD    = 16'h5A3C,
  parameter int          SYNC_TIMEOUT = 1024,
  localparam int         AW           = $clog2(PAGE_BYTES)
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_CEN_n,
  input  logic          i_START,
  input  logic          i_BIT_VALID,
  input  logic          i_BIT,
  output logic [7:0]    o_BYTE,
  output logic          o_BYTE_VALID,
  output logic [AW-1:0] o_BYTE_ADDR,
  output logic          o_BUSY,
  output logic          o_DONE,
  output logic          o_TIMEOUT,
  output logic          o_CRC_OK
);

  typedef enum logic [1:0] {IDLE, HUNT, RECV, DONE} state_t;

  state_t        state, state_nxt;
  logic [15:0]   window, window_nxt;
  logic [15:0]   tmo_cnt, tmo_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [AW-1:0] byte_cnt, byte_cnt_nxt;
  logic          emit, done_p, tmo_p;
  logic          crc_zero;

`ifdef K005297_DESER_CRC_EN
  logic [15:0] crc, crc_nxt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge i_CLK) begin
    if (i_RST)         crc <= 16'hFFFF;
    else if (!i_CEN_n) crc <= crc_nxt;
  end

  always_comb begin
    crc_nxt = crc;
    if (state == IDLE && i_START)           crc_nxt = 16'hFFFF;
    else if (state == RECV && i_BIT_VALID) crc_nxt = crc_step(crc, i_BIT);
  end

  // Appending the CRC bytes big-endian leaves a zero residue on a clean page.
  assign crc_zero = (crc == 16'h0000);
`else
  assign crc_zero = 1'b1;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST)         state <= IDLE;
    else if (!i_CEN_n) state <= state_nxt;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    window_nxt   = window;
    tmo_cnt_nxt  = tmo_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    byte_cnt_nxt = byte_cnt;
    emit         = 1'b0;
    done_p       = 1'b0;
    tmo_p        = 1'b0;
    case (state)
      IDLE: if (i_START) begin
        state_nxt    = HUNT;
        window_nxt   = '0;
        tmo_cnt_nxt  = '0;
        bit_cnt_nxt  = '0;
        byte_cnt_nxt = '0;
      end
      HUNT: if (i_BIT_VALID) begin
        window_nxt  = {window[14:0], i_BIT};
        tmo_cnt_nxt = tmo_cnt + 16'd1;
        // A match on the final allowed bit wins over the timeout.
        if (window_nxt == SYNC_WORD) begin
          state_nxt = RECV;
        end else if (tmo_cnt_nxt == 16'(SYNC_TIMEOUT)) begin
          tmo_p     = 1'b1;
          state_nxt = IDLE;
        end
      end
      RECV: if (i_BIT_VALID) begin
        shift_nxt   = {shift[6:0], i_BIT};
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          emit = 1'b1;
          if (byte_cnt == AW'(PAGE_BYTES - 1)) state_nxt = DONE;
          else                                  byte_cnt_nxt = byte_cnt + AW'(1);
        end
      end
      DONE: begin
        done_p    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath is reset
  // too so a page abandoned by i_RST leaves no stale window or counts behind.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      window       <= '0;
      tmo_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      byte_cnt     <= '0;
      o_BYTE       <= 8'h00;
      o_BYTE_ADDR  <= '0;
      o_BYTE_VALID <= 1'b0;
      o_BUSY       <= 1'b0;
      o_DONE       <= 1'b0;
      o_TIMEOUT    <= 1'b0;
      o_CRC_OK     <= 1'b0;
    end else if (!i_CEN_n) begin
      window       <= window_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      byte_cnt     <= byte_cnt_nxt;
      o_BYTE_VALID <= emit;
      if (emit) begin
        o_BYTE      <= shift_nxt;
        o_BYTE_ADDR <= byte_cnt;
      end
      o_BUSY       <= (state_nxt == HUNT) || (state_nxt == RECV);
      o_DONE       <= done_p;
      o_TIMEOUT    <= tmo_p;
      o_CRC_OK     <= done_p & crc_zero;
    end
  end

endmodule

// File: tb/tb_k005297_page_deserializer.sv
// Scoreboard bench for k005297_page_deserializer: a bit-stream model predicts byte,
// done and timeout events; a monitor pops and compares them on every enabled edge.
module tb_k005297_page_deserializer;

  localparam int          PAGE_BYTES = 4;
  localparam int          SYNC_TMO   = 32;
  localparam logic [15:0] SYNC       = 16'h5A3C;
  localparam int          AW         = $clog2(PAGE_BYTES);
  localparam int          EV_BYTE = 0, EV_DONE = 1, EV_TMO = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         addr;
    logic       ok;
  } ev_t;

  logic          i_CLK = 1'b0;
  logic          i_RST = 1'b1;
  logic          i_CEN_n = 1'b1;
  logic          i_START = 1'b0;
  logic          i_BIT_VALID = 1'b0;
  logic          i_BIT = 1'b0;
  logic [7:0]    o_BYTE;
  logic          o_BYTE_VALID;
  logic [AW-1:0] o_BYTE_ADDR;
  logic          o_BUSY, o_DONE, o_TIMEOUT, o_CRC_OK;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  bit  stim_q[$];

  k005297_page_deserializer #(
    .PAGE_BYTES(PAGE_BYTES), .SYNC_WORD(SYNC), .SYNC_TIMEOUT(SYNC_TMO)
  ) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CEN_n(i_CEN_n), .i_START(i_START),
    .i_BIT_VALID(i_BIT_VALID), .i_BIT(i_BIT), .o_BYTE(o_BYTE),
    .o_BYTE_VALID(o_BYTE_VALID), .o_BYTE_ADDR(o_BYTE_ADDR), .o_BUSY(o_BUSY),
    .o_DONE(o_DONE), .o_TIMEOUT(o_TIMEOUT), .o_CRC_OK(o_CRC_OK)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-16-CCITT, one bit at a time, straight from the polynomial definition.
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    logic fb;
    fb = c[15] ^ b;
    return fb ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
  endfunction

  function automatic logic [15:0] crc_bytes(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] c;
    logic [15:0] d;
    c = 16'hFFFF;
    d = {a, b};
    for (int i = 15; i >= 0; i--) c = crc_bit(c, d[i]);
    return c;
  endfunction

  function automatic void push_ev(input int kind, input logic [7:0] data, input int addr,
                                  input logic ok);
    ev_t e;
    e.kind = kind; e.data = data; e.addr = addr; e.ok = ok;
    exp_q.push_back(e);
  endfunction

  // Reference model: scans stim_q as the valid-bit stream after START, predicts events
  // (only the first max_bytes bytes when a reset will cut the page short) and reports
  // how many bits the DUT will consume.
  task automatic model(input int max_bytes, output int n_used);
    logic [15:0] w;
    logic [15:0] crc;
    logic [7:0]  by;
    int          sync_at, nb, lim;
    bit          ok;
    w = 16'h0000; sync_at = -1; n_used = 0; by = 8'h00;
    for (int i = 0; i < stim_q.size(); i++) begin
      w = {w[14:0], stim_q[i]};
      if (w == SYNC) begin sync_at = i; break; end
      if (i + 1 == SYNC_TMO) begin
        push_ev(EV_TMO, 8'h00, 0, 1'b0);
        n_used = i + 1;
        return;
      end
    end
    if (sync_at < 0 || stim_q.size() < sync_at + 1 + PAGE_BYTES * 8) begin
      $display("FAIL model_stimulus: bit stream too short (%0d bits)", stim_q.size());
      $fatal(1);
    end
    crc = 16'hFFFF; nb = 0;
    for (int k = 0; k < PAGE_BYTES * 8; k++) begin
      by  = {by[6:0], stim_q[sync_at + 1 + k]};
      crc = crc_bit(crc, stim_q[sync_at + 1 + k]);
      if (k % 8 == 7) begin
        if (nb < max_bytes) push_ev(EV_BYTE, by, nb, 1'b0);
        nb++;
      end
    end
    lim = (max_bytes < PAGE_BYTES) ? max_bytes : PAGE_BYTES;
    n_used = sync_at + 1 + lim * 8;
`ifdef K005297_DESER_CRC_EN
    ok = (crc == 16'h0000);
`else
    ok = 1'b1;
`endif
    if (max_bytes >= PAGE_BYTES) push_ev(EV_DONE, 8'h00, 0, ok);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim_q.push_back(b[i]);
  endtask

  task automatic build_page(input int noise, input logic [7:0] d0, input logic [7:0] d1,
                            input bit corrupt);
    logic [15:0] s;
    logic [15:0] c;
    s = SYNC;
    c = crc_bytes(d0, d1);
    stim_q.delete();
    for (int i = 0; i < noise; i++) stim_q.push_back(1'($urandom_range(1)));
    for (int i = 15; i >= 0; i--) stim_q.push_back(s[i]);
    push_byte(corrupt ? (d0 ^ 8'h01) : d0);
    push_byte(d1);
    push_byte(c[15:8]);
    push_byte(c[7:0]);
  endtask

  task automatic drive_cen(input int cen_div);
    i_CEN_n = (cen_div > 1) ? (($urandom_range(cen_div - 1)) != 0) : 1'b0;
  endtask

  task automatic do_start();
    @(negedge i_CLK);
    i_START = 1'b1; i_CEN_n = 1'b0;
    i_BIT_VALID = 1'($urandom_range(1)); i_BIT = 1'($urandom_range(1));
    @(posedge i_CLK); #1;
    check("busy_after_start", o_BUSY, 1);
  endtask

  task automatic drive_bit(input bit b, input int cen_div, input int gap_pct,
                           input bit start_noise);
    bit taken;
    int guard;
    taken = 0; guard = 0;
    while (!taken) begin
      @(negedge i_CLK);
      drive_cen(cen_div);
      i_BIT_VALID = ($urandom_range(99) >= gap_pct);
      i_BIT       = i_BIT_VALID ? b : 1'($urandom_range(1));
      i_START     = start_noise ? 1'($urandom_range(1)) : 1'b0;
      @(posedge i_CLK);
      if (!i_CEN_n && i_BIT_VALID) taken = 1;
      if (++guard > 2000) begin
        $display("FAIL drive_bit: bit never accepted");
        $fatal(1);
      end
    end
  endtask

  task automatic wait_drain(input int cen_div);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge i_CLK);
      drive_cen(cen_div);
      i_BIT_VALID = 1'b0; i_START = 1'b0;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_page(input int cen_div, input int gap_pct, input bit start_noise,
                          input int max_bytes);
    int n;
    model(max_bytes, n);
    do_start();
    for (int i = 0; i < n; i++) drive_bit(stim_q[i], cen_div, gap_pct, start_noise);
    wait_drain(cen_div);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"},  o_BYTE, 0);
    check({tag, "_addr"},  o_BYTE_ADDR, 0);
    check({tag, "_valid"}, o_BYTE_VALID, 0);
    check({tag, "_busy"},  o_BUSY, 0);
    check({tag, "_done"},  o_DONE, 0);
    check({tag, "_tmo"},   o_TIMEOUT, 0);
    check({tag, "_crcok"}, o_CRC_OK, 0);
  endtask

  // Monitor: one event per enabled edge; on disabled edges a raised pulse must hold.
  initial begin
    logic        rst_s, en_s;
    logic [31:0] prev, cur;
    ev_t         e;
    prev = '0;
    forever begin
      @(posedge i_CLK);
      rst_s = i_RST; en_s = !i_CEN_n;
      #1;
      cur = {19'd0, o_BYTE_VALID, o_DONE, o_TIMEOUT, o_BYTE, AW'(o_BYTE_ADDR)};
      if (rst_s) begin
        prev = '0;
      end else if (en_s) begin
        if (o_BYTE_VALID === 1'b1 || o_DONE === 1'b1 || o_TIMEOUT === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: valid=%0b done=%0b tmo=%0b byte=%0h addr=%0d",
                     o_BYTE_VALID, o_DONE, o_TIMEOUT, o_BYTE, o_BYTE_ADDR);
          end else begin
            e = exp_q.pop_front();
            if (o_BYTE_VALID) begin
              check("ev_kind_byte", EV_BYTE, e.kind);
              check("byte_data", o_BYTE, e.data);
              check("byte_addr", o_BYTE_ADDR, e.addr);
            end else if (o_DONE) begin
              check("ev_kind_done", EV_DONE, e.kind);
              check("crc_ok", o_CRC_OK, e.ok);
              check("busy_in_done", o_BUSY, 0);
            end else begin
              check("ev_kind_tmo", EV_TMO, e.kind);
              check("busy_after_tmo", o_BUSY, 0);
            end
          end
        end
        prev = cur;
      end else begin
        if (prev[AW+10:AW+8] != 3'b000) check("pulse_hold", cur, prev);
        prev = cur;
      end
    end
  end

  initial begin
    int n;
    // Reset with clock enable held off must still clear every output.
    i_RST = 1'b1; i_CEN_n = 1'b1;
    repeat (2) @(posedge i_CLK);
    #1 check_reset_outputs("reset");
    @(negedge i_CLK);
    i_RST = 1'b0;

    // Nominal page and its corrupted-data variant.
    build_page(3, 8'hA5, 8'h01, 1'b0);
    run_page(1, 0, 1'b0, PAGE_BYTES);
    build_page(3, 8'hA5, 8'h01, 1'b1);
    run_page(1, 0, 1'b0, PAGE_BYTES);

    // Timeout on all-zero stream; sync ending on bit 32 vs bit 33.
    stim_q.delete();
    for (int i = 0; i < 40; i++) stim_q.push_back(1'b0);
    run_page(1, 0, 1'b0, PAGE_BYTES);
    check("busy_idle_after_tmo", o_BUSY, 0);
    build_page(0, 8'h3C, 8'hC3, 1'b0);
    for (int i = 0; i < 16; i++) stim_q.push_front(1'b0);
    run_page(1, 0, 1'b0, PAGE_BYTES);
    build_page(0, 8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 17; i++) stim_q.push_front(1'b0);
    run_page(1, 0, 1'b0, PAGE_BYTES);

    // Enable at 1-in-4, random valid gaps and START chatter while busy.
    build_page(3, 8'hA5, 8'h01, 1'b0);
    run_page(4, 30, 1'b1, PAGE_BYTES);
    for (int t = 0; t < 6; t++) begin
      build_page($urandom_range(10), 8'($urandom), 8'($urandom), $urandom_range(3) == 0);
      run_page($urandom_range(1, 4), $urandom_range(40), 1'($urandom_range(1)), PAGE_BYTES);
    end

    // Reset after byte 1: no completion, outputs clear, next page starts at address 0.
    build_page(2, 8'h5E, 8'hE5, 1'b0);
    run_page(1, 0, 1'b0, 2);
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(1)), 1, 0, 1'b0);
    @(negedge i_CLK);
    i_RST = 1'b1; i_CEN_n = 1'b1; i_BIT_VALID = 1'b0;
    @(posedge i_CLK);
    #1 check_reset_outputs("midpage_reset");
    @(negedge i_CLK);
    i_RST = 1'b0; i_CEN_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_CLK);
      i_BIT_VALID = 1'($urandom_range(1)); i_BIT = 1'($urandom_range(1));
    end
    check("idle_after_reset", o_BUSY, 0);
    build_page(1, 8'h80, 8'h7F, 1'b0);
    run_page(2, 10, 1'b0, PAGE_BYTES);

    repeat (10) @(negedge i_CLK);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/k005297_page_deserializer.md
# k005297_page_deserializer

Serial-to-parallel receive stage for the bubble-memory read path of the K005297 controller. It takes the detector bit stream, hunts for the page sync word, assembles MSB-first bytes and numbers them within the page. It flags page completion or sync timeout. It sits directly downstream of the detector/latch primitives (DL, SRNAND) and feeds the page buffer write port.

## Interface
- PAGE_BYTES, 64: bytes per page after sync, including the 2 trailing CRC bytes; range 4..256.
- SYNC_WORD, 16'h5A3C: 16-bit sync pattern, MSB-first.
- SYNC_TIMEOUT, 1024: maximum valid bits in HUNT before giving up; range 17..65535.

Ports:
- i_CLK  in  1  master clock; one clock domain.
- i_RST  in  1  reset; synchronous, active-high.
- i_CEN_n  in  1  clock enable, active-low; all non-reset state updates occur only on enabled edges.
- i_START  in  1  begin a page read; sampled in IDLE only.
- i_BIT_VALID  in  1  i_BIT is valid on this enabled edge.
- i_BIT  in  1  detector data bit.
- o_BYTE  out  8  assembled byte; first received bit in bit 7.
- o_BYTE_VALID  out  1  o_BYTE/o_BYTE_ADDR valid; one-enabled-period pulse.
- o_BYTE_ADDR  out  $clog2(PAGE_BYTES)  index of o_BYTE in the page, 0-based.
- o_BUSY  out  1  high in HUNT and RECV.
- o_DONE  out  1  page completed; one-enabled-period pulse.
- o_TIMEOUT  out  1  sync not found; one-enabled-period pulse.
- o_CRC_OK  out  1  CRC result, valid while o_DONE is high.

## Operation
- States: IDLE, HUNT, RECV, DONE. Reset enters IDLE.
- IDLE, i_START=1: go to HUNT. Clear the 16-bit sync window, bit counter, byte counter and CRC (CRC to 16'hFFFF). i_BIT_VALID on the i_START edge is ignored.
- HUNT: each valid bit shifts into the window LSB (window <= {window[14:0], i_BIT}) and increments the timeout counter.
  - If the updated window equals SYNC_WORD, go to RECV. The sync bits are not output and not included in the CRC.
  - Otherwise, when the counter reaches SYNC_TIMEOUT, pulse o_TIMEOUT and go to IDLE.
  - A match on the SYNC_TIMEOUT-th bit counts as a match; no timeout is raised.
- RECV: each valid bit shifts into the byte register MSB-first.
  - On the 8th bit, o_BYTE is loaded with the full byte, o_BYTE_ADDR with the byte counter, and o_BYTE_VALID pulses. The byte counter increments.
  - After byte PAGE_BYTES-1 is emitted, go to DONE.
- DONE: pulse o_DONE and drive o_CRC_OK for one enabled period, then go to IDLE.
- i_START outside IDLE is ignored; there is no abort other than i_RST.
- i_BIT_VALID=0 holds all counters and shift registers.
- The byte counter does not wrap within a page; it is cleared on the next i_START.

## Timing
- All outputs are registered. Reset values on any rising i_CLK with i_RST=1, regardless of i_CEN_n:
  - o_BYTE=8'h00, o_BYTE_ADDR=0.
  - o_BYTE_VALID=0, o_BUSY=0, o_DONE=0, o_TIMEOUT=0, o_CRC_OK=0.
- i_RST mid-page abandons the page with no o_DONE or o_TIMEOUT.
- Byte latency: o_BYTE_VALID is high starting at the enabled edge that samples the byte's 8th bit.
- Pulse width: each pulse holds until the next enabled edge (one CEN period). The consumer samples pulses on enabled edges.
- o_DONE rises on the enabled edge after the last o_BYTE_VALID. The earliest next i_START is accepted one enabled edge after o_DONE.
- o_BUSY is 1 from the edge entering HUNT through the edge leaving RECV; it is 0 in DONE.
- With i_CEN_n=1, all state and outputs hold, including pulses.

## Configuration
- K005297_DESER_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final XOR) runs over every RECV bit, including the 2 trailing CRC bytes. At DONE, o_CRC_OK=1 iff the residue is 16'h0000.
- K005297_DESER_CRC_EN undefined: no CRC logic is built; o_CRC_OK=1 whenever o_DONE=1, else 0.

## Test plan
- Reset then idle: assert i_RST for 2 cycles with i_CEN_n=1 -> all outputs 0, state IDLE, o_BUSY=0.
- Nominal page, PAGE_BYTES=4: i_START, 3 noise bits, then 16'h5A3C, then bytes 8'hA5, 8'h01, CRC hi, CRC lo -> 4 o_BYTE_VALID pulses at addresses 0..3 with those values, then o_DONE=1 with o_CRC_OK=1.
- Corrupt CRC (macro on): same page with 8'hA5 replaced by 8'hA4 -> o_DONE=1, o_CRC_OK=0. With macro off -> o_CRC_OK=1.
- Timeout, SYNC_TIMEOUT=32: i_START then 32 valid 0 bits -> o_TIMEOUT pulses after the 32nd bit, state IDLE, no o_BYTE_VALID. Sync completing exactly on bit 32 -> RECV, no o_TIMEOUT.
- Enable and valid gaps: the nominal page with i_CEN_n toggling 1:3 and random i_BIT_VALID=0 gaps -> identical byte sequence and CRC result. Each pulse spans exactly one CEN period.
- Reset mid-page and START while busy: i_START during RECV -> ignored. i_RST after byte 1 -> outputs clear, no o_DONE. A new i_START then yields addresses starting at 0.
